// File: rtl/fadd7_seq.sv
// Multi-cycle adder for unsigned minifloats (1.mmmm x 2^e) with valid/ready on both sides.
// The smaller operand is aligned one bit per cycle, then the sum is normalized, rounded and saturated.
module fadd7_seq #(
  parameter int EXP_W    = 3,
  parameter int MAN_W    = 4,
  parameter bit ROUND_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W-1:0] a,
  input  logic [EXP_W+MAN_W-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W-1:0] c,
  output logic                   ovf
);
  localparam int W = EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] D_ONE = EXP_W'(1);
  localparam logic [EXP_W:0]   E_ONE = (EXP_W + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [EXP_W-1:0]   r_ex;
  logic [EXP_W-1:0]   r_d;
  logic [MAN_W:0]     r_mx;
  logic [MAN_W:0]     r_my;
  logic               r_g;
  logic [MAN_W+1:0]   r_sum;
  logic [EXP_W:0]     r_e;
  logic [MAN_W-1:0]   r_man;
  logic               r_r;
  logic [W-1:0]       r_c;
  logic               r_ovf;

  logic [EXP_W-1:0]   w_ea;
  logic [EXP_W-1:0]   w_eb;
  logic               w_swap;
  logic [W-1:0]       w_x;
  logic [W-1:0]       w_y;
  logic               w_inc;
  logic [MAN_W+1:0]   w_rnd;
  logic               w_carry;
  logic [MAN_W-1:0]   w_man_rnd;
  logic [EXP_W:0]     w_e_rnd;
  logic [W-1:0]       w_c_final;

  // Operand X always carries the larger exponent; ties keep a as X.
  assign w_ea   = a[W-1:MAN_W];
  assign w_eb   = b[W-1:MAN_W];
  assign w_swap = (w_eb > w_ea);
  assign w_x    = w_swap ? b : a;
  assign w_y    = w_swap ? a : b;

  assign w_inc     = ROUND_EN && r_r;
  assign w_rnd     = {1'b0, 1'b1, r_man} + {{(MAN_W+1){1'b0}}, w_inc};
  assign w_carry   = w_rnd[MAN_W+1];
  assign w_man_rnd = w_carry ? '0 : w_rnd[MAN_W-1:0];
  assign w_e_rnd   = w_carry ? (r_e + E_ONE) : r_e;
  // Exponent beyond the representable range saturates the whole result to all ones.
  assign w_c_final = w_e_rnd[EXP_W] ? '1 : {w_e_rnd[EXP_W-1:0], w_man_rnd};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_ALIGN;
      S_ALIGN: if (r_d == '0) w_state_next = S_ADD;
      S_ADD:   w_state_next = S_NORM;
      S_NORM:  w_state_next = S_ROUND;
      S_ROUND: w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex  <= '0;
      r_d   <= '0;
      r_mx  <= '0;
      r_my  <= '0;
      r_g   <= 1'b0;
      r_sum <= '0;
      r_e   <= '0;
      r_man <= '0;
      r_r   <= 1'b0;
      r_c   <= '0;
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ex  <= w_x[W-1:MAN_W];
            r_mx  <= {1'b1, w_x[MAN_W-1:0]};
            r_my  <= {1'b1, w_y[MAN_W-1:0]};
            r_d   <= w_x[W-1:MAN_W] - w_y[W-1:MAN_W];
            r_g   <= 1'b0;
            r_ovf <= 1'b0;
          end
        end
        S_ALIGN: begin
          // Bits falling off past the guard are dropped (no sticky bit).
          if (r_d != '0) begin
            r_g  <= r_my[0];
            r_my <= r_my >> 1;
            r_d  <= r_d - D_ONE;
          end
        end
        S_ADD: begin
          r_sum <= {1'b0, r_mx} + {1'b0, r_my};
          r_e   <= {1'b0, r_ex};
        end
        S_NORM: begin
          if (r_sum[MAN_W+1]) begin
            r_man <= r_sum[MAN_W:1];
            r_r   <= r_sum[0];
            r_e   <= r_e + E_ONE;
          end else begin
            r_man <= r_sum[MAN_W-1:0];
            r_r   <= r_g;
          end
        end
        S_ROUND: begin
          r_c   <= w_c_final;
          r_ovf <= w_e_rnd[EXP_W];
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign c         = r_c;
  assign ovf       = r_ovf;
endmodule

// File: tb/tb_fadd7_seq.sv
// Directed bench for fadd7_seq: hand-computed sums, latency, backpressure and async reset.
// A second instance with rounding disabled runs in lockstep for the truncation case.
module tb_fadd7_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [6:0] a;
  logic [6:0] b;
  logic       in_ready;
  logic       out_valid;
  logic [6:0] c;
  logic       ovf;
  logic       in_ready_t;
  logic       out_valid_t;
  logic [6:0] c_t;
  logic       ovf_t;

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  fadd7_seq #(.EXP_W(3), .MAN_W(4), .ROUND_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .ovf(ovf)
  );

  fadd7_seq #(.EXP_W(3), .MAN_W(4), .ROUND_EN(1'b0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
    .a(a), .b(b), .out_valid(out_valid_t), .out_ready(out_ready), .c(c_t), .ovf(ovf_t)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands, accept on the next edge, then count edges until out_valid (bounded).
  task automatic run_op(input logic [6:0] ta, input logic [6:0] tb_v, output int n);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_in_ready", in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    $display("op a=%b b=%b -> c=%b ovf=%b latency=%0d", ta, tb_v, c, ovf, n);
  endtask

  task automatic finish_op();
    @(posedge clk); #1;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", c, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(7'b1001000, 7'b1000000, lat);
    chk("eq_lat", lat, 4);
    chk("eq_c", c, 7'b1010100);
    chk("eq_ovf", ovf, 0);
    finish_op();

    run_op(7'b1010000, 7'b0110000, lat);
    chk("uneq_lat", lat, 6);
    chk("uneq_c", c, 7'b1010100);
    finish_op();

    run_op(7'b0110000, 7'b1010000, lat);
    chk("swap_lat", lat, 6);
    chk("swap_c", c, 7'b1010100);
    finish_op();

    run_op(7'b1001110, 7'b0001000, lat);
    chk("rnd_lat", lat, 8);
    chk("rnd_c", c, 7'b1010000);
    chk("trunc_valid", out_valid_t, 1);
    chk("trunc_c", c_t, 7'b1001111);
    finish_op();

    run_op(7'b1000001, 7'b1000000, lat);
    chk("lsb_lat", lat, 4);
    chk("lsb_c", c, 7'b1010001);
    finish_op();

    run_op(7'b1111000, 7'b1110000, lat);
    chk("ovf_lat", lat, 4);
    chk("ovf_c", c, 7'b1111111);
    chk("ovf_flag", ovf, 1);
    finish_op();

    out_ready = 1'b0;
    run_op(7'b1001000, 7'b1000000, lat);
    chk("bp_lat", lat, 4);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 7'h7F;
      b = 7'h00;
      @(posedge clk); #1;
      $display("backpressure cycle %0d: out_valid=%b c=%b in_ready=%b", i, out_valid, c, in_ready);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_c", c, 7'b1010100);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    finish_op();

    a = 7'b1110000;
    b = 7'b0000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("d7_busy", in_ready, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("reset mid-align: out_valid=%b c=%b ovf=%b in_ready=%b", out_valid, c, ovf, in_ready);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_c", c, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("held_rst_out_valid", out_valid, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    run_op(7'b1110000, 7'b0000000, lat);
    chk("d7_lat", lat, 11);
    chk("d7_c", c, 7'b1110000);
    chk("d7_ovf", ovf, 0);
    finish_op();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fadd7_seq.md
# fadd7_seq

Sequential controller and datapath for the 7-bit unsigned float adder: 3-bit exponent, 4-bit mantissa, implicit leading 1, value = 1.mmmm × 2^e. It extends the equal-exponent combinational adder to any exponent pair:
- swaps the operands so the larger exponent is first;
- aligns the smaller mantissa one bit per cycle;
- adds, normalizes, rounds half-up and detects overflow.

A valid/ready handshake sits on both sides, so the block can sit between an operand source and a result consumer in the float datapath.

## Interface
- EXP_W, 3, exponent width (bits [EXP_W+MAN_W-1:MAN_W])
- MAN_W, 4, stored mantissa width (bits [MAN_W-1:0]), hidden 1 not stored
- ROUND_EN, 1, 1 = round half-up on guard bit, 0 = truncate
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operands a, b valid
- in_ready  out  1  block accepts operands (high only in IDLE)
- a  in  EXP_W+MAN_W  operand A
- b  in  EXP_W+MAN_W  operand B
- out_valid  out  1  result c valid (high only in DONE)
- out_ready  in  1  consumer takes result
- c  out  EXP_W+MAN_W  sum
- ovf  out  1  exponent overflow; c saturated to all ones

## Operation
- States: IDLE, ALIGN, ADD, NORM, ROUND, DONE.
- IDLE → ALIGN on `in_valid & in_ready`. Capture on that edge:
  - if ea ≥ eb: X = a, Y = b; otherwise X = b, Y = a;
  - ex, mx = {1, X.man} (MAN_W+1 bits), my = {1, Y.man};
  - d = ex − ey (0..2^EXP_W−1), guard g = 0, ovf = 0.
- ALIGN, each cycle:
  - if d ≠ 0: g ← my[0], my ← my >> 1, d ← d − 1; stay in ALIGN;
  - if d = 0: go to ADD;
  - bits shifted past g are discarded (no sticky).
- ADD: sum ← mx + my (MAN_W+2 bits), e ← ex. Go to NORM.
- NORM:
  - if sum[MSB] = 1: man ← sum[MAN_W:1], r ← sum[0], e ← e + 1;
  - otherwise: man ← sum[MAN_W−1:0], r ← g;
  - go to ROUND.
- ROUND:
  - if ROUND_EN and r = 1: {1, man} + 1;
  - on carry-out: man ← 0, e ← e + 1;
  - exponent arithmetic uses EXP_W+1 bits; e > 2^EXP_W−1 sets ovf and forces c = all ones;
  - go to DONE.
- DONE:
  - out_valid = 1; c and ovf are held stable until out_ready;
  - `out_valid & out_ready` → IDLE;
  - no operand is accepted in the DONE cycle.
- in_valid while busy is ignored. The source holds the operands until in_ready.

## Timing
- Reset (rst_n low, async): state IDLE, out_valid 0, c 0, ovf 0, all internal registers 0. in_ready = 1 while in IDLE, including during reset.
- Reset mid-operation: the operation is abandoned and no result is emitted.
- Latency: out_valid rises d+4 rising edges after the accept edge.
  - d = 0 → 4 cycles; d = 7 → 11 cycles.
- Throughput: one result per d+6 cycles when out_ready is held high. DONE→IDLE takes 1 edge, and the next accept takes 1 edge.
- in_ready and out_valid are decoded from registered state (no combinational in→out path). c and ovf are registered.
- Backpressure: DONE is held indefinitely while out_ready = 0. Outputs are unchanged in that state.

## Test plan
- Equal exponents:
  - a = 7'b1001000, b = 7'b1000000 → c = 7'b1010100, ovf 0;
  - out_valid exactly 4 cycles after accept.
- Unequal exponents and swap:
  - a = 7'b1010000, b = 7'b0110000 → c = 7'b1010100 after 6 cycles;
  - a/b swapped → identical c and latency.
- Round with carry-out:
  - a = 7'b1001110, b = 7'b0001000 (d = 4, g = 1) → c = 7'b1010000 after 8 cycles;
  - with ROUND_EN = 0 → c = 7'b1001111.
- Round on sum LSB: a = 7'b1000001, b = 7'b1000000 → c = 7'b1010001.
- Overflow: a = 7'b1111000, b = 7'b1110000 → c = 7'b1111111, ovf 1.
- Handshake and reset:
  - hold out_ready = 0 for 5 cycles in DONE → c and out_valid stable, in_ready 0, pulsing in_valid ignored;
  - then assert rst_n = 0 mid-ALIGN (d = 7) → out_valid and c are 0 immediately, in_ready = 1;
  - after release, next operation completes correctly.
